// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: INTCON bit positions,
// FSM state encodings and irq_source codes.
package interrupt_sequencer_pkg;

    localparam int GIE_BIT  = 7;
    localparam int PEIE_BIT = 6;
    localparam int T0IE_BIT = 5;
    localparam int INTE_BIT = 4;
    localparam int RBIE_BIT = 3;
    localparam int T0IF_BIT = 2;
    localparam int INTF_BIT = 1;
    localparam int RBIF_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_VECTOR  = 3'd3,
        ST_ISR     = 3'd4
    } irq_state_e;

    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_INT  = 3'd1;
    localparam logic [2:0] SRC_TMR0 = 3'd2;
    localparam logic [2:0] SRC_RB   = 3'd3;
    localparam logic [2:0] SRC_PERI = 3'd4;

endpackage

// File: rtl/interrupt_sequencer_irq_flag_combiner.sv
// Combinational flag combining and fixed-priority source encoding.
// Holds no state; the sequencer registers everything it needs.
module irq_flag_combiner
    import interrupt_sequencer_pkg::*;
(
    input  logic [7:0] intcon,
    input  logic [7:0] pir1,
    input  logic [7:0] pie1,
    output logic       any_flag,
    output logic       pending_d,
    output logic [2:0] src_code
);

    logic int_hit;
    logic t0_hit;
    logic rb_hit;
    logic peri_hit;

    assign int_hit  = intcon[INTE_BIT] & intcon[INTF_BIT];
    assign t0_hit   = intcon[T0IE_BIT] & intcon[T0IF_BIT];
    assign rb_hit   = intcon[RBIE_BIT] & intcon[RBIF_BIT];
    assign peri_hit = intcon[PEIE_BIT] & (|(pie1 & pir1));

    assign any_flag  = int_hit | t0_hit | rb_hit | peri_hit;
    assign pending_d = intcon[GIE_BIT] & any_flag;

    // Priority INT > TMR0 > RB > peripheral.
    always_comb begin
        src_code = SRC_NONE;
        if (int_hit) begin
            src_code = SRC_INT;
        end else if (t0_hit) begin
            src_code = SRC_TMR0;
        end else if (rb_hit) begin
            src_code = SRC_RB;
        end else if (peri_hit) begin
            src_code = SRC_PERI;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: waits for an instruction boundary,
// forces NOP for one instruction cycle, vectors, then tracks the ISR.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no interrupt in progress
// ST_PENDING | enabled flag seen, waiting for the next instruction boundary
// ST_FLUSH   | irq_flush held for FLUSH_CYCLES clk (down-counter)
// ST_VECTOR  | one clk: push PC, load vector, clear GIE, latch source
// ST_ISR     | servicing; leave on RETFIE
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [12:0] VECTOR_ADDR  = 13'h0004,
    parameter int          FLUSH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  intcon,
    input  logic [7:0]  pir1,
    input  logic [7:0]  pie1,
    input  logic        instr_boundary,
    input  logic        retfie_exec,
    input  logic        sleep_active,
    output logic        irq_flush,
    output logic        irq_push_en,
    output logic [12:0] irq_vector,
    output logic        gie_clr_en,
    output logic        gie_set_en,
    output logic        wake,
    output logic        irq_active,
    output logic [2:0]  irq_source
);

    localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    irq_state_e       state_q;
    irq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pending_q;
    logic             wake_cond_q;
    logic             wake_q;
    logic             gie_set_q;
    logic [2:0]       src_q;

    logic             any_flag;
    logic             pending_d;
    logic [2:0]       src_code;
    logic             wake_cond;

    irq_flag_combiner u_flag_combiner (
        .intcon    (intcon),
        .pir1      (pir1),
        .pie1      (pie1),
        .any_flag  (any_flag),
        .pending_d (pending_d),
        .src_code  (src_code)
    );

    assign wake_cond = sleep_active & any_flag;

    // Flag sampling, wake edge detect, RETFIE pulse and source latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q   <= 1'b0;
            wake_cond_q <= 1'b0;
            wake_q      <= 1'b0;
            gie_set_q   <= 1'b0;
            src_q       <= SRC_NONE;
        end else begin
            pending_q   <= pending_d;
            wake_cond_q <= wake_cond;
            wake_q      <= wake_cond & ~wake_cond_q;
            gie_set_q   <= retfie_exec;
            if (state_q == ST_VECTOR) begin
                src_q <= src_code;
            end
        end
    end

    // FSM state and flush down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and per-state outputs; flag inputs reach here only via pending_q.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        irq_flush   = 1'b0;
        irq_push_en = 1'b0;
        gie_clr_en  = 1'b0;
        irq_active  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (!pending_q) begin
                    state_d = ST_IDLE;
                end else if (instr_boundary) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_FLUSH: begin
                irq_flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_VECTOR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_VECTOR: begin
                irq_push_en = 1'b1;
                gie_clr_en  = 1'b1;
                state_d     = ST_ISR;
            end
            ST_ISR: begin
                irq_active = 1'b1;
                if (retfie_exec) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The source is visible in the vectoring clk itself, then held.
    assign irq_source = (state_q == ST_VECTOR) ? src_code : src_q;
    assign irq_vector = VECTOR_ADDR;
    assign gie_set_en = gie_set_q;
    assign wake       = wake_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer with a tiny core model that
// clears/sets GIE in response to gie_clr_en/gie_set_en.
module tb_interrupt_sequencer;

    logic        clk;
    logic        rst;
    logic [7:0]  intcon;
    logic [7:0]  pir1;
    logic [7:0]  pie1;
    logic        instr_boundary;
    logic        retfie_exec;
    logic        sleep_active;
    logic        irq_flush;
    logic        irq_push_en;
    logic [12:0] irq_vector;
    logic        gie_clr_en;
    logic        gie_set_en;
    logic        wake;
    logic        irq_active;
    logic [2:0]  irq_source;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit bnd_en   = 0;

    int          flush_cnt, flush_first, push_cnt, push_cyc;
    int          set_cnt, set_cyc, wake_cnt, wake_cyc;
    logic [2:0]  push_src;
    logic        push_clr;
    logic [12:0] push_vec;

    interrupt_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .intcon         (intcon),
        .pir1           (pir1),
        .pie1           (pie1),
        .instr_boundary (instr_boundary),
        .retfie_exec    (retfie_exec),
        .sleep_active   (sleep_active),
        .irq_flush      (irq_flush),
        .irq_push_en    (irq_push_en),
        .irq_vector     (irq_vector),
        .gie_clr_en     (gie_clr_en),
        .gie_set_en     (gie_set_en),
        .wake           (wake),
        .irq_active     (irq_active),
        .irq_source     (irq_source)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // One clk; the core model applies GIE updates requested in the cycle just ended.
    task automatic tick();
        logic clr_seen;
        logic set_seen;
        clr_seen = gie_clr_en;
        set_seen = gie_set_en;
        @(posedge clk);
        #1;
        if (clr_seen) intcon[7] = 1'b0;
        if (set_seen) intcon[7] = 1'b1;
        cyc++;
        instr_boundary = bnd_en && (cyc % 4 == 0);
    endtask

    task automatic clear_stats();
        flush_cnt = 0; flush_first = 0; push_cnt = 0; push_cyc = 0;
        set_cnt = 0; set_cyc = 0; wake_cnt = 0; wake_cyc = 0;
        push_src = 3'd0; push_clr = 1'b0; push_vec = 13'd0;
    endtask

    task automatic run_watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (irq_flush) begin
                if (flush_cnt == 0) flush_first = cyc;
                flush_cnt++;
            end
            if (irq_push_en) begin
                push_cnt++;
                push_cyc = cyc;
                push_src = irq_source;
                push_clr = gie_clr_en;
                push_vec = irq_vector;
            end
            if (gie_set_en) begin
                set_cnt++;
                set_cyc = cyc;
            end
            if (wake) begin
                wake_cnt++;
                wake_cyc = cyc;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        intcon = 8'h00; pir1 = 8'h00; pie1 = 8'h00;
        retfie_exec = 1'b0; sleep_active = 1'b0;
        bnd_en = 0; instr_boundary = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    logic [7:0] v_intcon [5] = '{8'hFF, 8'hC9, 8'hC0, 8'h80, 8'hA6};
    logic [7:0] v_pe     [5] = '{8'h00, 8'h01, 8'h10, 8'h10, 8'h00};
    int         v_src    [5] = '{1, 3, 4, 0, 2};
    int         v_push   [5] = '{1, 1, 1, 0, 1};

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state with busy inputs: every output but irq_vector stays low.
        rst = 1'b0;
        intcon = 8'hA4; pir1 = 8'hFF; pie1 = 8'hFF;
        retfie_exec = 1'b1; sleep_active = 1'b1; instr_boundary = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_flush",  irq_flush,   0);
        check_eq("rst_push",   irq_push_en, 0);
        check_eq("rst_clr",    gie_clr_en,  0);
        check_eq("rst_set",    gie_set_en,  0);
        check_eq("rst_wake",   wake,        0);
        check_eq("rst_active", irq_active,  0);
        check_eq("rst_source", irq_source,  0);
        check_eq("rst_vector", irq_vector,  13'h0004);

        // Test 1: TMR0 interrupt, boundary every 4th clk.
        do_reset();
        intcon = 8'hA4; bnd_en = 1;
        clear_stats();
        run_watch(12);
        check_eq("t1_flush_first", flush_first, 5);
        check_eq("t1_flush_cnt",   flush_cnt,   4);
        check_eq("t1_push_cnt",    push_cnt,    1);
        check_eq("t1_push_cyc",    push_cyc,    9);
        check_eq("t1_push_src",    push_src,    2);
        check_eq("t1_push_clr",    push_clr,    1);
        check_eq("t1_push_vec",    push_vec,    13'h0004);
        check_eq("t1_active",      irq_active,  1);
        check_eq("t1_src_held",    irq_source,  2);

        // Test 5: RETFIE in ISR with T0IF still set, re-entry after GIE returns.
        retfie_exec = 1'b1;
        clear_stats();
        run_watch(1);
        retfie_exec = 1'b0;
        check_eq("t5_set_now",    gie_set_en,  1);
        check_eq("t5_left_isr",   irq_active,  0);
        run_watch(10);
        check_eq("t5_set_cnt",    set_cnt,     1);
        check_eq("t5_set_cyc",    set_cyc,     13);
        check_eq("t5_flush_first", flush_first, 17);
        check_eq("t5_flush_cnt",  flush_cnt,   4);
        check_eq("t5_push_cnt",   push_cnt,    1);
        check_eq("t5_push_cyc",   push_cyc,    21);

        // Test 2: wake from SLEEP with GIE=0, no vectoring.
        do_reset();
        intcon = 8'h52; sleep_active = 1'b1; bnd_en = 1;
        clear_stats();
        run_watch(10);
        check_eq("t2_wake_cnt",  wake_cnt,  1);
        check_eq("t2_wake_cyc",  wake_cyc,  1);
        check_eq("t2_push_cnt",  push_cnt,  0);
        check_eq("t2_flush_cnt", flush_cnt, 0);
        sleep_active = 1'b0;

        // Test 3: source priority and enable gating.
        for (int k = 0; k < 5; k++) begin
            do_reset();
            intcon = v_intcon[k]; pie1 = v_pe[k]; pir1 = v_pe[k]; bnd_en = 1;
            clear_stats();
            run_watch(10);
            check_eq($sformatf("t3_push_cnt_%0d", k), push_cnt, v_push[k]);
            check_eq($sformatf("t3_src_%0d", k),      push_src, v_src[k]);
        end

        // Test 4: flag drops while waiting for the boundary.
        do_reset();
        intcon = 8'hA4; bnd_en = 1;
        clear_stats();
        run_watch(2);
        intcon = 8'hA0;
        run_watch(10);
        check_eq("t4_flush_cnt", flush_cnt, 0);
        check_eq("t4_push_cnt",  push_cnt,  0);

        // Flag drop inside FLUSH does not abort the sequence.
        do_reset();
        intcon = 8'hA4; bnd_en = 1;
        clear_stats();
        run_watch(6);
        intcon = 8'hA0;
        run_watch(6);
        check_eq("t7_flush_cnt", flush_cnt, 4);
        check_eq("t7_push_cnt",  push_cnt,  1);
        check_eq("t7_push_cyc",  push_cyc,  9);

        // RETFIE outside ISR: gie_set_en pulses, state stays IDLE.
        do_reset();
        bnd_en = 1; retfie_exec = 1'b1;
        tick();
        retfie_exec = 1'b0;
        check_eq("t8_set_now",  gie_set_en, 1);
        check_eq("t8_active",   irq_active, 0);
        tick();
        check_eq("t8_set_gone", gie_set_en, 0);
        intcon = 8'hA4;
        clear_stats();
        run_watch(8);
        check_eq("t8_push_cyc", push_cyc, 9);

        // Test 6: async reset on the 2nd FLUSH clk.
        do_reset();
        intcon = 8'hA4; bnd_en = 1;
        clear_stats();
        run_watch(6);
        check_eq("t6_in_flush", irq_flush, 1);
        rst = 1'b0;
        #1;
        check_eq("t6_flush_killed", irq_flush, 0);
        intcon = 8'hA0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        clear_stats();
        run_watch(20);
        check_eq("t6_push_cnt",  push_cnt,  0);
        check_eq("t6_flush_cnt", flush_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
